// File: rtl/mic1_mem_pkg.sv
// Shared types and helpers for the MIC-1 memory arbiter.
// Holds the FSM/data-op enums, bus widths and the byte-lane selector.
package mic1_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH
    } state_t;

    typedef enum logic {
        RD,
        WR
    } data_op_t;

    // Little-endian lane pick: lane 0 is bits 7:0.
    function automatic logic [7:0] byte_lane(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        lane
    );
        logic [7:0] b;
        unique case (lane)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Single shared memory port with a ready-based completion handshake.
// master = arbiter side, slave = memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_rd,
        output mem_wr,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_rd,
        input  mem_wr,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/mem_byte_sel.sv
// Combinational byte extract from a memory word by byte offset.
// Feeds MBR on fetch completion.
module mem_byte_sel
    import mic1_mem_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        lane,
    output logic [7:0]        byte_out
);

    assign byte_out = byte_lane(word, lane);

endmodule

// File: rtl/mem_arbiter.sv
// MIC-1 memory arbiter: serialises read/write/fetch onto one memory port.
// Define MEM_ARB_RR_EN for round-robin data/fetch arbitration.
module mem_arbiter
    import mic1_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        fetch_req,
    input  logic [31:0] mar,
    input  logic [31:0] mdr_wdata,
    input  logic [31:0] pc,
    output logic [31:0] mdr_rdata,
    output logic        mdr_load,
    output logic [7:0]  mbr_data,
    output logic        mbr_load,
    output logic        stall,
    output logic        err,
    mem_arbiter_if.master mem
);

    state_t      state;
    state_t      state_nxt;

    logic        d_pend;
    data_op_t    d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        f_pend;
    logic [31:0] f_pc;

    logic        d_req;
    logic        f_req;
    logic        d_first;
    logic        d_done;
    logic        f_done;
    logic [7:0]  f_byte;

    assign stall = d_pend | f_pend;

    // New work is only taken while nothing is outstanding.
    assign d_req  = ~stall & (rd_req | wr_req);
    assign f_req  = ~stall & fetch_req;
    assign d_done = (state == DATA) & mem.mem_ready;
    assign f_done = (state == FETCH) & mem.mem_ready;

`ifdef MEM_ARB_RR_EN
    logic last_data;

    always_ff @(posedge clk) begin
        if (rst)
            last_data <= 1'b0;
        else if (d_req && f_req)
            last_data <= d_first;
    end

    assign d_first = ~last_data;
`else
    assign d_first = 1'b1;
`endif

    mem_byte_sel u_byte_sel (
        .word     (mem.mem_rdata),
        .lane     (f_pc[1:0]),
        .byte_out (f_byte)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (d_req && (!f_req || d_first))
                    state_nxt = DATA;
                else if (f_req)
                    state_nxt = FETCH;
            end
            DATA: begin
                if (mem.mem_ready)
                    state_nxt = f_pend ? FETCH : IDLE;
            end
            FETCH: begin
                if (mem.mem_ready)
                    state_nxt = d_pend ? DATA : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_rd    = 1'b0;
        mem.mem_wr    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        unique case (state)
            DATA: begin
                mem.mem_rd    = (d_op == RD);
                mem.mem_wr    = (d_op == WR);
                mem.mem_addr  = d_addr << 2;
                mem.mem_wdata = d_wdata;
            end
            FETCH: begin
                mem.mem_rd   = 1'b1;
                mem.mem_addr = {f_pc[31:2], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_pend    <= 1'b0;
            d_op      <= RD;
            d_addr    <= '0;
            d_wdata   <= '0;
            f_pend    <= 1'b0;
            f_pc      <= '0;
            mdr_rdata <= '0;
            mdr_load  <= 1'b0;
            mbr_data  <= '0;
            mbr_load  <= 1'b0;
            err       <= 1'b0;
        end else begin
            mdr_load <= 1'b0;
            mbr_load <= 1'b0;
            err      <= 1'b0;
            // rd+wr together: the write wins and the read is dropped.
            if (d_req) begin
                d_pend  <= 1'b1;
                d_op    <= wr_req ? WR : RD;
                d_addr  <= mar;
                d_wdata <= mdr_wdata;
                err     <= rd_req & wr_req;
            end
            if (f_req) begin
                f_pend <= 1'b1;
                f_pc   <= pc;
            end
            if (d_done) begin
                d_pend <= 1'b0;
                if (d_op == RD) begin
                    mdr_rdata <= mem.mem_rdata;
                    mdr_load  <= 1'b1;
                end
            end
            if (f_done) begin
                f_pend   <= 1'b0;
                mbr_data <= f_byte;
                mbr_load <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter against a transaction-level model.
// Randomised requests and wait states; checks bus, strobes, stall, err.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic        wr_req;
    logic        fetch_req;
    logic [31:0] mar;
    logic [31:0] mdr_wdata;
    logic [31:0] pc;
    logic [31:0] mdr_rdata;
    logic        mdr_load;
    logic [7:0]  mbr_data;
    logic        mbr_load;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit rr_last_data = 1'b0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem ();

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .fetch_req (fetch_req),
        .mar       (mar),
        .mdr_wdata (mdr_wdata),
        .pc        (pc),
        .mdr_rdata (mdr_rdata),
        .mdr_load  (mdr_load),
        .mbr_data  (mbr_data),
        .mbr_load  (mbr_load),
        .stall     (stall),
        .err       (err),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        fetch_req = 1'b0;
    endtask

    // One accept, then serve each expected command with its wait states.
    task automatic run_cmd(
        input string       tag,
        input logic        rd,
        input logic        wr,
        input logic        fe,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [31:0] p,
        input int          w0,
        input int          w1,
        input logic [31:0] rd0,
        input logic [31:0] rd1,
        input bit          hold
    );
        logic [31:0] ex_addr[2];
        logic [31:0] ex_wd[2];
        logic        ex_rd[2];
        logic        ex_wr[2];
        logic        ex_fe[2];
        logic [31:0] rdat[2];
        int          ws[2];
        int          n;
        int          guard;
        bit          dfirst;
        bit          take_d;
        logic        exp_mdr;
        logic        exp_mbr;
        logic [7:0]  exp_byte;

        n = 0;
        guard = 0;
        while (stall === 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_wait stall=%b want 0", tag, stall);
        end

        dfirst = 1'b1;
        if ((rd | wr) && fe) begin
`ifdef MEM_ARB_RR_EN
            dfirst = !rr_last_data;
            rr_last_data = dfirst;
`endif
        end
        for (int s = 0; s < 2; s++) begin
            take_d = ((s == 0) == dfirst);
            if (take_d && (rd | wr)) begin
                ex_rd[n] = !wr;
                ex_wr[n] = wr;
                ex_fe[n] = 1'b0;
                ex_addr[n] = a << 2;
                ex_wd[n] = wd;
                n++;
            end else if (!take_d && fe) begin
                ex_rd[n] = 1'b1;
                ex_wr[n] = 1'b0;
                ex_fe[n] = 1'b1;
                ex_addr[n] = p & 32'hFFFF_FFFC;
                ex_wd[n] = '0;
                n++;
            end
        end
        ws[0] = w0;
        ws[1] = w1;
        rdat[0] = rd0;
        rdat[1] = rd1;

        rd_req    = rd;
        wr_req    = wr;
        fetch_req = fe;
        mar       = a;
        mdr_wdata = wd;
        pc        = p;
        tick();
        if (!hold)
            clear_in();

        checks++;
        if (err !== (rd & wr)) begin
            errors++;
            $display("FAIL %s err got=%b want=%b", tag, err, rd & wr);
        end

        for (int i = 0; i < n; i++) begin
            for (int k = 0; k <= ws[i]; k++) begin
                checks++;
                if (mem.mem_rd !== ex_rd[i] || mem.mem_wr !== ex_wr[i] ||
                    mem.mem_addr !== ex_addr[i] ||
                    (ex_wr[i] && mem.mem_wdata !== ex_wd[i])) begin
                    errors++;
                    $display("FAIL %s bus cmd%0d rd=%b wr=%b addr=%h wd=%h want rd=%b wr=%b addr=%h wd=%h",
                             tag, i, mem.mem_rd, mem.mem_wr, mem.mem_addr,
                             mem.mem_wdata, ex_rd[i], ex_wr[i], ex_addr[i], ex_wd[i]);
                end
                checks++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_stall cmd%0d got=%b want 1", tag, i, stall);
                end
                if (k == ws[i]) begin
                    mem.mem_ready = 1'b1;
                    mem.mem_rdata = rdat[i];
                end else begin
                    mem.mem_ready = 1'b0;
                    mem.mem_rdata = $urandom;
                end
                tick();
            end
            mem.mem_ready = 1'b0;
            if (i == n - 1)
                clear_in();

            exp_mdr  = ex_rd[i] && !ex_fe[i];
            exp_mbr  = ex_fe[i];
            exp_byte = 8'(rdat[i] >> (8 * p[1:0]));
            checks++;
            if (mdr_load !== exp_mdr || (exp_mdr && mdr_rdata !== rdat[i])) begin
                errors++;
                $display("FAIL %s mdr cmd%0d load=%b data=%h want load=%b data=%h",
                         tag, i, mdr_load, mdr_rdata, exp_mdr, rdat[i]);
            end
            checks++;
            if (mbr_load !== exp_mbr || (exp_mbr && mbr_data !== exp_byte)) begin
                errors++;
                $display("FAIL %s mbr cmd%0d load=%b data=%h want load=%b data=%h",
                         tag, i, mbr_load, mbr_data, exp_mbr, exp_byte);
            end
            checks++;
            if (stall !== (i != n - 1) || err !== 1'b0) begin
                errors++;
                $display("FAIL %s done_stall cmd%0d stall=%b err=%b want stall=%b err=0",
                         tag, i, stall, err, i != n - 1);
            end
        end

        tick();
        checks++;
        if (mem.mem_rd !== 1'b0 || mem.mem_wr !== 1'b0 || stall !== 1'b0 ||
            mdr_load !== 1'b0 || mbr_load !== 1'b0) begin
            errors++;
            $display("FAIL %s after rd=%b wr=%b stall=%b mdr_load=%b mbr_load=%b want all 0",
                     tag, mem.mem_rd, mem.mem_wr, stall, mdr_load, mbr_load);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_in();
        mar = '0;
        mdr_wdata = '0;
        pc = '0;
        mem.mem_ready = 1'b0;
        mem.mem_rdata = '0;
        tick();
        tick();
        checks++;
        if ({mdr_load, mbr_load, stall, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b want 0000", {mdr_load, mbr_load, stall, err});
        end
        checks++;
        if (mdr_rdata !== 32'h0 || mbr_data !== 8'h0) begin
            errors++;
            $display("FAIL reset_data mdr=%h mbr=%h want 0", mdr_rdata, mbr_data);
        end
        checks++;
        if (mem.mem_rd !== 1'b0 || mem.mem_wr !== 1'b0 ||
            mem.mem_addr !== 32'h0 || mem.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus rd=%b wr=%b addr=%h wd=%h want 0",
                     mem.mem_rd, mem.mem_wr, mem.mem_addr, mem.mem_wdata);
        end
        rst = 1'b0;
        rr_last_data = 1'b0;
        tick();
    endtask

    task automatic test_idle_ready();
        mem.mem_ready = 1'b1;
        mem.mem_rdata = 32'hCAFE_F00D;
        tick();
        tick();
        mem.mem_ready = 1'b0;
        checks++;
        if (mdr_load !== 1'b0 || mbr_load !== 1'b0 || stall !== 1'b0 ||
            mem.mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready mdr_load=%b mbr_load=%b stall=%b rd=%b want 0",
                     mdr_load, mbr_load, stall, mem.mem_rd);
        end
    endtask

    task automatic test_read();
        run_cmd("read", 1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 0,
                32'hDEAD_BEEF, 32'h0, 1'b0);
    endtask

    task automatic test_fetch();
        run_cmd("fetch", 0, 0, 1, 32'h0, 32'h0, 32'h103, 3, 0,
                32'h1122_3344, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_cmd("wr_fetch1", 0, 1, 1, 32'h20, 32'hA5A5_0001, 32'h201, 1, 2,
                32'h0, 32'h5566_7788, 1'b0);
        run_cmd("wr_fetch2", 0, 1, 1, 32'h24, 32'hA5A5_0002, 32'h302, 0, 0,
                32'h0, 32'h99AA_BBCC, 1'b0);
    endtask

    task automatic test_err();
        run_cmd("rd_wr", 1, 1, 0, 32'h33, 32'h1234_5678, 32'h0, 2, 0,
                32'hFFFF_0000, 32'h0, 1'b0);
    endtask

    task automatic test_hold();
        run_cmd("hold", 1, 0, 1, 32'h44, 32'h0, 32'h2F0, 2, 1,
                32'h0BAD_F00D, 32'h7766_5544, 1'b1);
    endtask

    task automatic test_reset_mid();
        fetch_req = 1'b1;
        pc = 32'h0000_0405;
        tick();
        clear_in();
        checks++;
        if (mem.mem_rd !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre rd=%b stall=%b want 1 1", mem.mem_rd, stall);
        end
        tick();
        rst = 1'b1;
        mem.mem_ready = 1'b1;
        mem.mem_rdata = 32'hDEAD_0000;
        tick();
        rst = 1'b0;
        rr_last_data = 1'b0;
        checks++;
        if (mem.mem_rd !== 1'b0 || stall !== 1'b0 || mbr_load !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_now rd=%b stall=%b mbr_load=%b want 0",
                     mem.mem_rd, stall, mbr_load);
        end
        tick();
        mem.mem_ready = 1'b0;
        checks++;
        if (mem.mem_rd !== 1'b0 || stall !== 1'b0 || mbr_load !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_late rd=%b stall=%b mbr_load=%b want 0",
                     mem.mem_rd, stall, mbr_load);
        end
    endtask

    task automatic test_random();
        logic rd;
        logic wr;
        logic fe;
        for (int it = 0; it < 30; it++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            fe = 1'($urandom_range(0, 1));
            if (!rd && !wr && !fe)
                fe = 1'b1;
            run_cmd($sformatf("rand%0d", it), rd, wr, fe, $urandom, $urandom,
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_ready();
        test_read();
        test_fetch();
        test_back_to_back();
        test_err();
        test_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
